load_store_unit: RTL and testbench

Memory-access stage directly downstream of the ALU. Takes the ALU's 32-bit result as the effective address and the second register operand as store data. Runs a multi-cycle handshake with the data memory and returns sign- or zero-extended load data to write-back. It stalls the pipeline while an access is outstanding and reports misaligned, illegal and timed-out accesses as a single-cycle fault.

---
 rtl/load_store_unit_pkg.sv | 42 ++++
 rtl/lsu_align.sv | 58 +++++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared funct3 codes, FSM states and request-check helpers
// for the load/store unit.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;
  localparam logic [2:0] LSU_SB  = 3'b000;
  localparam logic [2:0] LSU_SH  = 3'b001;
  localparam logic [2:0] LSU_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  function automatic logic lsu_legal(
    input logic       ld,
    input logic [2:0] f3
  );
    if (ld)
      return f3 inside {LSU_LB, LSU_LH, LSU_LW,
                        LSU_LBU, LSU_LHU};
    return f3 inside {LSU_SB, LSU_SH, LSU_SW};
  endfunction

  // f3[1:0] encodes size for both loads and stores
  function automatic logic lsu_aligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    case (f3[1:0])
      2'b01:   return !off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane steering / byte enables and load lane
// extraction with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic        i_store,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_sdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_sdata;
    if (i_store) begin
      case (i_f3)
        LSU_SB: begin
          o_wdata = {4{i_sdata[7:0]}};
          o_be    = 4'b0001 << i_off;
        end
        LSU_SH: begin
          o_wdata = {2{i_sdata[15:0]}};
          o_be    = 4'b0011 << i_off;
        end
        default: begin
          o_wdata = i_sdata;
          o_be    = 4'b1111;
        end
      endcase
    end
  end

  assign w_shift = i_rdata >> {i_ld_off, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_shift[15:0];

  always_comb begin
    o_ldata = w_shift;
    case (i_ld_f3)
      LSU_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
      LSU_LH:  o_ldata = {{16{w_half[15]}}, w_half};
      LSU_LBU: o_ldata = {24'd0, w_byte};
      LSU_LHU: o_ldata = {16'd0, w_half};
      default: o_ldata = w_shift;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: request checks, memory handshake FSM
// with timeout, and load write-back.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 is_load,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] store_data,
  input  logic [4:0]           rd_in,
  input  logic                 flush,
  output logic                 stall,
  output logic                 mem_cen,
  output logic                 mem_wen,
  output logic [ADDR_BITS-3:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 wb_valid,
  output logic [4:0]           wb_rd,
  output logic [DATA_BITS-1:0] wb_data,
  output logic                 fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t r_state, w_next;

  logic [ADDR_BITS-3:0] r_addr;
  logic [3:0]           r_be;
  logic [DATA_BITS-1:0] r_wdata, r_wb_data;
  logic                 r_store, r_fault;
  logic [2:0]           r_f3;
  logic [1:0]           r_off;
  logic [4:0]           r_rd;
  logic [CW-1:0]        r_cnt;

  logic                 w_open, w_one, w_ok;
  logic                 w_accept, w_req_fault;
  logic                 w_in_acc, w_done, w_timeout;
  logic [3:0]           w_be;
  logic [DATA_BITS-1:0] w_wdata, w_ldata;

  assign w_open   = (r_state != S_ACCESS);
  assign w_one    = is_load ^ is_store;
  assign w_ok     = lsu_legal(is_load, funct3)
                  & lsu_aligned(funct3, addr[1:0]);
  assign w_accept = w_open & req_valid & w_one
                  & !flush & w_ok;
  assign w_req_fault = w_open & req_valid & !flush
                     & ((is_load & is_store)
                     | (w_one & !w_ok));

  assign w_in_acc  = (r_state == S_ACCESS);
  assign w_done    = w_in_acc & mem_ready;
  assign w_timeout = w_in_acc & !mem_ready
                   & (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  lsu_align u_align (
    .i_f3     (funct3),
    .i_store  (is_store),
    .i_off    (addr[1:0]),
    .i_sdata  (store_data),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .i_ld_f3  (r_f3),
    .i_ld_off (r_off),
    .i_rdata  (mem_rdata),
    .o_ldata  (w_ldata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RESP:
        w_next = w_accept ? S_ACCESS : S_IDLE;
      S_ACCESS: begin
        if (mem_ready)
          w_next = r_store ? S_IDLE : S_RESP;
        else if (w_timeout)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_store   <= 1'b0;
      r_f3      <= '0;
      r_off     <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_wb_data <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fault <= w_req_fault | w_timeout;
      if (w_accept) begin
        r_addr  <= addr[ADDR_BITS-1:2];
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_store <= is_store;
        r_f3    <= funct3;
        r_off   <= addr[1:0];
        r_rd    <= rd_in;
        r_cnt   <= '0;
      end else if (w_in_acc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_done & !r_store)
        r_wb_data <= w_ldata;
    end
  end

  assign stall     = w_in_acc | w_accept;
  assign mem_cen   = w_in_acc;
  assign mem_wen   = w_in_acc & r_store;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign wb_valid  = (r_state == S_RESP);
  assign wb_rd     = r_rd;
  assign wb_data   = r_wb_data;
  assign fault     = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads through a
// write-back scoreboard, faults, timeout and mid-access reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, is_load, is_store, flush;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [4:0]  rd_in;
  logic        stall, mem_cen, mem_wen;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fault;

  int checks   = 0;
  int failures = 0;

  logic [36:0] sb_q[$];
  logic [36:0] sb_e;

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_BITS      (32),
    .DATA_BITS      (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .flush      (flush),
    .stall      (stall),
    .mem_cen    (mem_cen),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .fault      (fault)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_valid  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    rd_in      = 5'd0;
    flush      = 1'b0;
  endtask

  // One accepted access; waits = wait states before mem_ready.
  task automatic run_op(
    input logic        ld,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [4:0]  rd,
    input int          waits,
    input logic [31:0] rdata,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wd,
    input logic [31:0] exp_wb
  );
    req_valid  = 1'b1;
    is_load    = ld;
    is_store   = !ld;
    funct3     = f3;
    addr       = a;
    store_data = d;
    rd_in      = rd;
    #1;
    check("accept_stall", {31'd0, stall}, 32'd1);
    if (ld) sb_q.push_back({rd, exp_wb});
    tick();
    idle_in();
    for (int i = 0; i <= waits; i++) begin
      check("acc_cen", {31'd0, mem_cen}, 32'd1);
      check("acc_wen", {31'd0, mem_wen}, {31'd0, !ld});
      check("acc_stall", {31'd0, stall}, 32'd1);
      check("acc_addr", {2'b00, mem_addr}, {2'b00, a[31:2]});
      check("acc_be", {28'd0, mem_be}, {28'd0, exp_be});
      if (!ld) check("acc_wdata", mem_wdata, exp_wd);
      mem_rdata = rdata;
      mem_ready = (i == waits);
      tick();
    end
    mem_ready = 1'b0;
    check("post_cen", {31'd0, mem_cen}, 32'd0);
    check("wb_valid", {31'd0, wb_valid}, {31'd0, ld});
    if (ld && wb_valid) begin
      check("sb_nonempty", sb_q.size(), 32'd1);
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        check("wb_rd", {27'd0, wb_rd}, {27'd0, sb_e[36:32]});
        check("wb_data", wb_data, sb_e[31:0]);
      end
    end
  endtask

  // Request that must be rejected; exp_f = expected fault pulse.
  task automatic reject_op(
    input string       tag,
    input logic        ld,
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic        fl,
    input logic        exp_f
  );
    req_valid = 1'b1;
    is_load   = ld;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    flush     = fl;
    #1;
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    tick();
    idle_in();
    check({tag, "_fault"}, {31'd0, fault}, {31'd0, exp_f});
    check({tag, "_cen"}, {31'd0, mem_cen}, 32'd0);
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    tick();
    check({tag, "_fault_clr"}, {31'd0, fault}, 32'd0);
  endtask

  initial begin
    idle_in();
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_cen", {31'd0, mem_cen}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op(1'b0, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0,
           32'h0, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_op(1'b0, 3'b000, 32'h103, 32'h000000A5, 5'd0, 1,
           32'h0, 4'b1000, 32'hA5A5A5A5, 32'h0);
    run_op(1'b0, 3'b001, 32'h102, 32'h00001234, 5'd0, 0,
           32'h0, 4'b1100, 32'h12341234, 32'h0);

    // Back-to-back loads: each accepted in the previous RESP
    run_op(1'b1, 3'b000, 32'h102, 32'h0, 5'd3, 0,
           32'h80FF7F01, 4'b1111, 32'h0, 32'hFFFFFFFF);
    run_op(1'b1, 3'b100, 32'h102, 32'h0, 5'd4, 0,
           32'h80FF7F01, 4'b1111, 32'h0, 32'h000000FF);
    run_op(1'b1, 3'b001, 32'h102, 32'h0, 5'd5, 1,
           32'h80FF7F01, 4'b1111, 32'h0, 32'hFFFF80FF);
    run_op(1'b1, 3'b101, 32'h102, 32'h0, 5'd6, 0,
           32'h80FF7F01, 4'b1111, 32'h0, 32'h000080FF);
    run_op(1'b1, 3'b000, 32'h101, 32'h0, 5'd7, 0,
           32'h80FF7F01, 4'b1111, 32'h0, 32'h0000007F);
    run_op(1'b1, 3'b010, 32'h104, 32'h0, 5'd8, 2,
           32'h80FF7F01, 4'b1111, 32'h0, 32'h80FF7F01);
    tick();

    reject_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h102, 1'b0, 1'b1);
    reject_op("sh_mis", 1'b0, 1'b1, 3'b001, 32'h101, 1'b0, 1'b1);
    reject_op("ill_f3", 1'b1, 1'b0, 3'b011, 32'h100, 1'b0, 1'b1);
    reject_op("st_f3", 1'b0, 1'b1, 3'b100, 32'h100, 1'b0, 1'b1);
    reject_op("both", 1'b1, 1'b1, 3'b010, 32'h100, 1'b0, 1'b1);
    reject_op("neither", 1'b0, 1'b0, 3'b010, 32'h100, 1'b0, 1'b0);
    reject_op("flush_mis", 1'b1, 1'b0, 3'b010, 32'h102, 1'b1, 1'b0);
    reject_op("flush_ok", 1'b1, 1'b0, 3'b010, 32'h100, 1'b1, 1'b0);

    // Timeout: four ACCESS cycles with no mem_ready
    req_valid = 1'b1;
    is_load   = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0;
    rd_in     = 5'd9;
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      check("to_cen", {31'd0, mem_cen}, 32'd1);
      tick();
    end
    check("to_cen_off", {31'd0, mem_cen}, 32'd0);
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_stall", {31'd0, stall}, 32'd0);
    check("to_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    check("to_fault_clr", {31'd0, fault}, 32'd0);
    check("to_wbv2", {31'd0, wb_valid}, 32'd0);

    // Reset during an access with three wait states
    req_valid = 1'b1;
    is_load   = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h200;
    rd_in     = 5'd10;
    tick();
    idle_in();
    mem_rdata = 32'hCAFEF00D;
    tick();
    check("pre_rst_cen", {31'd0, mem_cen}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_cen", {31'd0, mem_cen}, 32'd0);
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_addr", {2'b00, mem_addr}, 32'd0);
    check("mid_rst_be", {28'd0, mem_be}, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("post_rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("post_rst_fault", {31'd0, fault}, 32'd0);
    run_op(1'b1, 3'b010, 32'h0, 32'h0, 5'd11, 0,
           32'h12345678, 4'b1111, 32'h0, 32'h12345678);
    tick();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
